// File: rtl/pulse_receiver_symbol_decoder.sv
// Pulse-train receiver: measures each level segment, classifies it into a
// 2-bit {level, long} symbol, packs 16 symbols per word into a 2-entry buffer.
module pulse_receiver_symbol_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        sig_in,
    input  logic        invert,
    input  logic        idle_level,
    input  logic [3:0]  prescaler,
    input  logic [7:0]  threshold,
    input  logic [7:0]  timeout,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_len,
    output logic        out_last,
    output logic        frame_end,
    output logic        overflow,
    input  logic        overflow_clr
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic        s_q, s_prev;
    logic        sig_edge;
    logic [14:0] tick_cnt;
    logic [15:0] tick_span;
    logic        tick;
    logic [7:0]  dur;
    logic [31:0] pack, pack_ins;
    logic [3:0]  cnt;
    logic [1:0]  sym;
    logic        emit, timeout_hit, word_full, push;
    logic [37:0] push_word;
    logic [37:0] mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic        pop, full, accept, drop;

    assign sig_edge  = (s_q != s_prev);
    assign tick_span = (16'd1 << prescaler) - 16'd1;
    assign tick      = (tick_cnt == tick_span[14:0]);
    assign sym       = {s_prev, (dur > threshold)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= 1'b0;
            s_prev <= 1'b0;
        end else if (!en) begin
            s_q    <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s_q    <= sig_in ^ invert;
            s_prev <= s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (!en)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // An edge always beats a timeout landing in the same cycle.
    always_comb begin
        state_nxt   = state;
        emit        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (sig_edge && (s_q != idle_level))
                    state_nxt = RUN;
            end
            RUN: begin
                if (sig_edge) begin
                    emit = 1'b1;
                end else if ((s_q == idle_level) && (timeout != 8'd0) &&
                             (dur == timeout)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pack_ins                    = pack;
        pack_ins[{cnt, 1'b0} +: 2]  = sym;
    end

    assign word_full = emit && (cnt == 4'd15);
    assign push      = word_full || timeout_hit;
    assign push_word = word_full ? {1'b0, 5'd16, pack_ins}
                                 : {1'b1, 1'b0, cnt, pack};

    // The tick in an edge cycle is discarded along with the duration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            dur      <= '0;
        end else if (!en || (state == IDLE) || sig_edge) begin
            tick_cnt <= '0;
            dur      <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            if (dur != 8'hff)
                dur <= dur + 8'd1;
        end else begin
            tick_cnt <= tick_cnt + 15'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack      <= '0;
            cnt       <= '0;
            frame_end <= 1'b0;
        end else if (!en) begin
            pack      <= '0;
            cnt       <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= timeout_hit;
            if (push) begin
                pack <= '0;
                cnt  <= '0;
            end else if (emit) begin
                pack <= pack_ins;
                cnt  <= cnt + 4'd1;
            end
        end
    end

    assign pop    = out_valid && out_ready;
    assign full   = (count == 2'd2);
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (!en) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    assign out_valid = (count != 2'd0);
    assign {out_last, out_len, out_data} = mem[rd_ptr];

endmodule
